// File: rtl/dbus_access_unit_pkg.sv
// Shared data-bus types for the memory stage.
// Holds the access size enum, the bus request/response structs, the byte
// strobe alias and the state enum of the data-bus access FSM.
// No ports.
package dbus_access_unit_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef logic [7:0] strobe_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        strobe_t     strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    // Kept separate from the older mem_access_state_t on purpose.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dbus_state_t;

endpackage

// File: rtl/dbus_access_unit_if.sv
// Bundle between the memory stage, the data bus and dbus_access_unit.
// master: pipeline/bus side (drives req_*, downstream_stall, dresp).
// slave : the access unit (drives dreq, stall, done, rdata, misaligned).
interface dbus_access_unit_if;
    import dbus_access_unit_pkg::*;

    logic        req_valid;
    logic        req_write;
    logic [63:0] req_addr;
    msize_t      req_size;
    logic        req_unsigned;
    logic [63:0] req_wdata;
    logic        downstream_stall;
    dbus_req_t   dreq;
    dbus_resp_t  dresp;
    logic        stall;
    logic        done;
    logic [63:0] rdata;
    logic        misaligned;

    modport master (
        output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
        output downstream_stall, dresp,
        input  dreq, stall, done, rdata, misaligned
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
        input  downstream_stall, dresp,
        output dreq, stall, done, rdata, misaligned
    );

endinterface

// File: rtl/dbus_access_unit_align.sv
// Combinational lane alignment for the 64-bit data bus.
// Ports:
//   off       in  byte offset within the 64-bit lane (addr[2:0])
//   size      in  access size
//   write     in  1 = store (strobe produced), 0 = load (strobe 0)
//   wdata     in  right-justified store value
//   rdata_raw in  raw bus read data
//   zext      in  zero-extend instead of sign-extend
//   strobe    out byte enables
//   wdata_al  out store data shifted onto its byte lane
//   rdata_ext out extracted and extended load value
module dbus_align
    import dbus_access_unit_pkg::*;
(
    input  logic [2:0]  off,
    input  msize_t      size,
    input  logic        write,
    input  logic [63:0] wdata,
    input  logic [63:0] rdata_raw,
    input  logic        zext,
    output strobe_t     strobe,
    output logic [63:0] wdata_al,
    output logic [63:0] rdata_ext
);

    logic [5:0]  shamt;
    logic [31:0] lane;

    assign shamt    = {off, 3'b000};
    assign wdata_al = wdata << shamt;
    // Only the low word of the shifted read data can feed a sub-doubleword load.
    assign lane     = 32'(rdata_raw >> shamt);

    always_comb begin
        strobe = '0;
        if (write) begin
            case (size)
                MSIZE1:  strobe = strobe_t'(8'h01 << off);
                MSIZE2:  strobe = strobe_t'(8'h03 << off);
                MSIZE4:  strobe = strobe_t'(8'h0F << off);
                default: strobe = 8'hFF;
            endcase
        end
    end

    always_comb begin
        rdata_ext = rdata_raw;
        case (size)
            MSIZE1:  rdata_ext = zext ? {56'd0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
            MSIZE2:  rdata_ext = zext ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
            MSIZE4:  rdata_ext = zext ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
            default: rdata_ext = rdata_raw;
        endcase
    end

endmodule

// File: rtl/dbus_access_unit.sv
// Memory-stage data-bus adapter: one pipeline memory op -> one aligned bus
// transaction, held stable until data_ok; stalls the pipeline meanwhile.
// Ports:
//   clk   in  clock
//   reset in  synchronous, active-high reset
//   bus   slave side of dbus_access_unit_if (request in, dreq/dresp bus,
//         stall/done/rdata/misaligned back to the pipeline)
module dbus_access_unit
    import dbus_access_unit_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    dbus_access_unit_if.slave  bus
);

    dbus_state_t state;
    logic [63:0] addr_q, data_q, rdata_q;
    msize_t      size_q;
    strobe_t     strobe_q;
    logic        unsigned_q;
    logic        done_q;

    logic        bad_align, issue, accept, in_idle;
    logic [2:0]  cur_off;
    msize_t      cur_size;
    logic        cur_unsigned;
    strobe_t     strobe_live;
    logic [63:0] wdata_live, load_ext;

    always_comb begin
        bad_align = 1'b0;
        case (bus.req_size)
            MSIZE2:  bad_align = bus.req_addr[0];
            MSIZE4:  bad_align = |bus.req_addr[1:0];
            MSIZE8:  bad_align = |bus.req_addr[2:0];
            default: bad_align = 1'b0;
        endcase
    end

    assign bus.misaligned = bus.req_valid & bad_align;
    assign in_idle        = (state == IDLE);
    assign issue          = in_idle & bus.req_valid & ~bus.misaligned;
    assign accept         = (issue | (state == WAIT)) & bus.dresp.data_ok;
    assign bus.stall      = issue | (state == WAIT);
    assign bus.done       = done_q;
    assign bus.rdata      = rdata_q;

    // Live request fields only matter in the issue cycle; afterwards the
    // latched copies steer load extraction so req_* may change freely.
    assign cur_off      = in_idle ? bus.req_addr[2:0] : addr_q[2:0];
    assign cur_size     = in_idle ? bus.req_size      : size_q;
    assign cur_unsigned = in_idle ? bus.req_unsigned  : unsigned_q;

    dbus_align u_align (
        .off       (cur_off),
        .size      (cur_size),
        .write     (bus.req_write),
        .wdata     (bus.req_wdata),
        .rdata_raw (bus.dresp.data),
        .zext      (cur_unsigned),
        .strobe    (strobe_live),
        .wdata_al  (wdata_live),
        .rdata_ext (load_ext)
    );

    always_comb begin
        if (issue) begin
            bus.dreq.valid  = 1'b1;
            bus.dreq.addr   = bus.req_addr;
            bus.dreq.size   = bus.req_size;
            bus.dreq.strobe = strobe_live;
            bus.dreq.data   = wdata_live;
        end else begin
            bus.dreq.valid  = (state == WAIT);
            bus.dreq.addr   = addr_q;
            bus.dreq.size   = size_q;
            bus.dreq.strobe = strobe_q;
            bus.dreq.data   = data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            size_q     <= MSIZE1;
            strobe_q   <= '0;
            unsigned_q <= 1'b0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        addr_q     <= bus.req_addr;
                        data_q     <= wdata_live;
                        size_q     <= bus.req_size;
                        strobe_q   <= strobe_live;
                        unsigned_q <= bus.req_unsigned;
                        state      <= bus.dresp.data_ok ? DONE : WAIT;
                        done_q     <= bus.dresp.data_ok;
                    end
                end
                WAIT: begin
                    if (bus.dresp.data_ok) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (!bus.downstream_stall) begin
                        state  <= IDLE;
                        done_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
            endcase
            if (accept) rdata_q <= load_ext;
        end
    end

endmodule

// File: tb/tb_dbus_access_unit.sv
// Directed bench for dbus_access_unit: stores/loads at several offsets,
// back-to-back issue, misalignment, reset mid-access and downstream stall.
module tb_dbus_access_unit;
    import dbus_access_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dbus_access_unit_if bus ();

    dbus_access_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int sc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Starts in an IDLE cycle; returns in the first DONE cycle with req_valid low.
    // From the second cycle on req_* are scrambled to prove the latched copy drives dreq.
    task automatic issue_access(input logic wr, input logic [63:0] addr, input msize_t sz,
                                input logic uns, input logic [63:0] wd, input logic [63:0] resp,
                                input int n, input logic [7:0] exp_strb,
                                input logic [63:0] exp_data, output int stall_cyc);
        bus.req_valid        = 1'b1;
        bus.req_write        = wr;
        bus.req_addr         = addr;
        bus.req_size         = sz;
        bus.req_unsigned     = uns;
        bus.req_wdata        = wd;
        bus.downstream_stall = 1'b0;
        stall_cyc = 0;
        for (int k = 0; k <= n; k++) begin
            if (k > 0) begin
                bus.req_wdata    = ~wd;
                bus.req_addr     = addr ^ 64'h100;
                bus.req_unsigned = ~uns;
            end
            bus.dresp.data_ok = (k == n);
            bus.dresp.data    = (k == n) ? resp : 64'hDEAD_BEEF_DEAD_BEEF;
            #1;
            if (bus.stall) stall_cyc++;
            chk("dreq_valid",  64'(bus.dreq.valid),  64'd1);
            chk("dreq_addr",   bus.dreq.addr,        addr);
            chk("dreq_size",   64'(bus.dreq.size),   64'(sz));
            chk("dreq_strobe", 64'(bus.dreq.strobe), 64'(exp_strb));
            chk("dreq_data",   bus.dreq.data,        exp_data);
            tick();
        end
        bus.dresp.data_ok = 1'b0;
        bus.req_valid     = 1'b0;
    endtask

    // Checks the DONE cycle, then moves to the following (IDLE) cycle.
    task automatic check_done(input logic [63:0] exp_rdata);
        #1;
        chk("done",       64'(bus.done),       64'd1);
        chk("done_stall", 64'(bus.stall),      64'd0);
        chk("done_valid", 64'(bus.dreq.valid), 64'd0);
        chk("rdata",      bus.rdata,           exp_rdata);
        tick();
    endtask

    task automatic check_no_done(input string tag);
        #1;
        chk(tag, 64'(bus.done), 64'd0);
        tick();
    endtask

    initial begin
        reset                = 1'b1;
        bus.req_valid        = 1'b0;
        bus.req_write        = 1'b0;
        bus.req_addr         = '0;
        bus.req_size         = MSIZE1;
        bus.req_unsigned     = 1'b0;
        bus.req_wdata        = '0;
        bus.downstream_stall = 1'b0;
        bus.dresp.data_ok    = 1'b0;
        bus.dresp.data       = '0;

        // Reset state
        tick(); tick();
        #1;
        chk("rst_valid",  64'(bus.dreq.valid),  64'd0);
        chk("rst_addr",   bus.dreq.addr,        64'd0);
        chk("rst_data",   bus.dreq.data,        64'd0);
        chk("rst_strobe", 64'(bus.dreq.strobe), 64'd0);
        chk("rst_size",   64'(bus.dreq.size),   64'd0);
        chk("rst_rdata",  bus.rdata,            64'd0);
        chk("rst_done",   64'(bus.done),        64'd0);
        chk("rst_stall",  64'(bus.stall),       64'd0);
        chk("rst_misal",  64'(bus.misaligned),  64'd0);
        reset = 1'b0;
        tick();

        // SB, data_ok 3 cycles after issue: 4 stall cycles, single done pulse
        issue_access(1'b1, 64'h8000_0003, MSIZE1, 1'b0, 64'hAB, 64'd0, 3,
                     8'h08, 64'h0000_0000_AB00_0000, sc);
        chk("sb_stall_cycles", 64'(sc), 64'd4);
        check_done(64'd0);
        check_no_done("sb_done_pulse");

        // SH at offset 6
        issue_access(1'b1, 64'h0000_1006, MSIZE2, 1'b0, 64'h1234, 64'd0, 1,
                     8'hC0, 64'h1234_0000_0000_0000, sc);
        chk("sh_stall_cycles", 64'(sc), 64'd2);
        check_done(64'd0);
        tick();

        // SD with data_ok in the issue cycle, LB issued right behind it
        issue_access(1'b1, 64'h0000_2000, MSIZE8, 1'b0, 64'h0123_4567_89AB_CDEF, 64'd0, 0,
                     8'hFF, 64'h0123_4567_89AB_CDEF, sc);
        chk("sd_stall_cycles", 64'(sc), 64'd1);
        check_done(64'd0);
        issue_access(1'b0, 64'h8000_0005, MSIZE1, 1'b0, 64'd0, 64'h0000_8000_0000_0000, 2,
                     8'h00, 64'd0, sc);
        chk("lb_stall_cycles", 64'(sc), 64'd3);
        check_done(64'hFFFF_FFFF_FFFF_FF80);

        // LBU of the same byte
        issue_access(1'b0, 64'h8000_0005, MSIZE1, 1'b1, 64'd0, 64'h0000_8000_0000_0000, 1,
                     8'h00, 64'd0, sc);
        check_done(64'h0000_0000_0000_0080);

        // LW then LWU at offset 4, back to back
        issue_access(1'b0, 64'h8000_0004, MSIZE4, 1'b0, 64'd0, 64'h8765_4321_0000_0000, 0,
                     8'h00, 64'd0, sc);
        check_done(64'hFFFF_FFFF_8765_4321);
        issue_access(1'b0, 64'h8000_0004, MSIZE4, 1'b1, 64'd0, 64'h8765_4321_0000_0000, 0,
                     8'h00, 64'd0, sc);
        check_done(64'h0000_0000_8765_4321);

        // LH at offset 2
        issue_access(1'b0, 64'h0001_0002, MSIZE2, 1'b0, 64'd0, 64'h0000_0000_8001_0000, 1,
                     8'h00, 64'd0, sc);
        check_done(64'hFFFF_FFFF_FFFF_8001);

        // Misaligned LW at offset 2: no bus activity, no stall, no done
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 64'h8000_0002;
        bus.req_size  = MSIZE4;
        #1;
        chk("mis_lw_flag",  64'(bus.misaligned), 64'd1);
        chk("mis_lw_valid", 64'(bus.dreq.valid), 64'd0);
        chk("mis_lw_stall", 64'(bus.stall),      64'd0);
        tick();
        #1;
        chk("mis_lw_done",  64'(bus.done),       64'd0);
        chk("mis_lw_valid2", 64'(bus.dreq.valid), 64'd0);
        bus.req_addr = 64'h0000_0005;
        bus.req_size = MSIZE2;
        #1;
        chk("mis_sh_flag", 64'(bus.misaligned), 64'd1);
        bus.req_addr = 64'h0000_0004;
        bus.req_size = MSIZE8;
        #1;
        chk("mis_sd_flag", 64'(bus.misaligned), 64'd1);
        bus.req_valid = 1'b0;
        #1;
        chk("mis_novalid", 64'(bus.misaligned), 64'd0);
        tick();

        // data_ok in IDLE is ignored
        bus.dresp.data_ok = 1'b1;
        tick();
        bus.dresp.data_ok = 1'b0;
        #1;
        chk("idle_dataok_done", 64'(bus.done), 64'd0);
        chk("idle_dataok_rdata", bus.rdata, 64'hFFFF_FFFF_FFFF_8001);
        tick();

        // Reset while in WAIT abandons the access
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 64'h0000_3000;
        bus.req_size  = MSIZE8;
        tick();
        bus.req_valid = 1'b0;
        #1;
        chk("wait_valid", 64'(bus.dreq.valid), 64'd1);
        chk("wait_stall", 64'(bus.stall),      64'd1);
        reset             = 1'b1;
        bus.dresp.data_ok = 1'b1;
        bus.dresp.data    = 64'h5555_5555_5555_5555;
        tick();
        #1;
        chk("rstw_valid", 64'(bus.dreq.valid), 64'd0);
        chk("rstw_rdata", bus.rdata,           64'd0);
        chk("rstw_done",  64'(bus.done),       64'd0);
        chk("rstw_stall", 64'(bus.stall),      64'd0);
        reset             = 1'b0;
        bus.dresp.data_ok = 1'b0;
        tick();
        check_no_done("rstw_done2");

        // downstream_stall holds DONE; no new request while held
        issue_access(1'b0, 64'h8000_0005, MSIZE1, 1'b1, 64'd0, 64'h0000_8000_0000_0000, 1,
                     8'h00, 64'd0, sc);
        bus.downstream_stall = 1'b1;
        bus.req_valid        = 1'b1;
        bus.req_addr         = 64'h8000_0005;
        bus.req_size         = MSIZE1;
        #1;
        chk("ds_done_a",  64'(bus.done),       64'd1);
        chk("ds_valid_a", 64'(bus.dreq.valid), 64'd0);
        chk("ds_rdata",   bus.rdata,           64'h80);
        tick();
        #1;
        chk("ds_done_b",  64'(bus.done),       64'd1);
        chk("ds_valid_b", 64'(bus.dreq.valid), 64'd0);
        chk("ds_stall_b", 64'(bus.stall),      64'd0);
        tick();
        bus.downstream_stall = 1'b0;
        bus.req_valid        = 1'b0;
        #1;
        chk("ds_done_c",  64'(bus.done),       64'd1);
        tick();
        #1;
        chk("ds_done_d",  64'(bus.done),       64'd0);
        chk("ds_valid_d", 64'(bus.dreq.valid), 64'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dbus_access_unit.md
# dbus_access_unit

Memory-stage bus adapter between the execute/memory pipeline registers and the data bus (`dbus_req_t`/`dbus_resp_t`). It turns one pipeline memory operation into exactly one aligned bus transaction and holds the request stable until `data_ok`. It aligns store data and strobes to the 64-bit bus lane and extracts and sign/zero-extends load data. It raises a pipeline stall for the whole duration of the access.

## Interface
Parameters: none.
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `req_valid`  in  1  memory-stage instruction performs a load/store
- `req_write`  in  1  1 = store, 0 = load
- `req_addr`  in  64  byte address
- `req_size`  in  `msize_t`  MSIZE1/2/4/8
- `req_unsigned`  in  1  zero-extend load (LBU/LHU/LWU)
- `req_wdata`  in  64  store value, right-justified
- `downstream_stall`  in  1  pipeline frozen by another cause
- `dreq`  out  `dbus_req_t`  bus request
- `dresp`  in  `dbus_resp_t`  bus response
- `stall`  out  1  freeze stages at and before memory
- `done`  out  1  access complete; `rdata` valid
- `rdata`  out  64  extended load result, registered
- `misaligned`  out  1  address not a multiple of size

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - When `req_valid & !misaligned`, issue: compute strobe/data, latch addr, size, strobe, data and unsigned into request registers, and drive `dreq` from the live values this cycle.
  - If `data_ok` arrives in the same cycle, go to DONE; otherwise go to WAIT.
- WAIT: `dreq.valid=1` from the latched registers. On `data_ok`, capture the extended data into `rdata` and go to DONE.
- DONE: `done=1`, `stall=0`.
  - Stay in DONE while `downstream_stall`; there is no re-issue.
  - Otherwise go to IDLE.
- `stall` = (IDLE & `req_valid` & !`misaligned`) | WAIT.
- Store alignment, with off = `addr[2:0]`:
  - strobe: MSIZE1 → `8'h01<<off`, MSIZE2 → `8'h03<<off`, MSIZE4 → `8'h0F<<off`, MSIZE8 → `8'hFF`.
  - data: `wdata << (off*8)`.
  - Loads: strobe `8'h00`.
- Load extraction: `dresp.data >> (off*8)`, truncated to size, then sign-extended, or zero-extended when `req_unsigned`. MSIZE8 passes through unchanged.
- `misaligned`:
  - Combinational: `req_valid` & (MSIZE2 & `addr[0]` | MSIZE4 & `addr[1:0]`≠0 | MSIZE8 & `addr[2:0]`≠0).
  - No bus transaction, no stall, no `done`. Trap handling lives elsewhere.
- Changes to `req_*` while in WAIT are ignored because the latched registers drive `dreq`.

## Timing
- Reset values: state IDLE; `dreq.valid`=0; `dreq` addr/data/strobe/size all 0; `rdata`=0; `done`=0. `stall` and `misaligned` are combinational and 0 when `req_valid`=0.
- Latency is from the issue cycle to `done`:
  - 1 cycle when `data_ok` arrives in the issue cycle.
  - N+1 cycles when `data_ok` arrives N cycles after issue.
- The request is held stable, bit-exact, from issue until the cycle `data_ok` is sampled. `dreq.valid` drops the cycle after.
- `done` is high for exactly one cycle, or for more cycles while `downstream_stall`.
- Back-to-back: a new access can issue in the IDLE cycle directly after DONE. The minimum is 2 cycles per access.
- Reset in WAIT: the next cycle is IDLE with `dreq.valid`=0, no `done` pulse, and the outstanding transaction is abandoned.
- A `data_ok` seen in IDLE or DONE is ignored.

## Structure
- Shared package (`common`) holds:
  - `msize_t`, `dbus_req_t`, `dbus_resp_t`.
  - A new `dbus_state_t` enum {IDLE, WAIT, DONE}, distinct from `mem_access_state_t`.
  - A `strobe_t` alias (8 bits).
- One combinational sub-module, `dbus_align`, covers store strobe/data shifting and load extraction, so it can be tested in isolation.
- The top contains only the FSM and the request/`rdata` registers.

## Test plan
- SB: addr `0x80000003`, wdata `0xAB`, `data_ok` 3 cycles after issue → strobe `0x08`, data `0xAB000000`, `stall` for 4 cycles, one `done` pulse.
- LB: addr offset 5, response `0x0000800000000000` → `rdata` `0xFFFFFFFFFFFFFF80`. The same access as LBU → `0x80`.
- LW: offset 4, response `0x87654321_00000000` → `rdata` `0xFFFFFFFF87654321`. As LWU → `0x0000000087654321`.
- `data_ok` in the issue cycle → `stall` 1 cycle, `done` the next cycle, then a second access issues immediately.
- LW at offset 2 → `misaligned`=1, `dreq.valid`=0, `stall`=0, no `done`.
- Reset asserted in WAIT → `dreq.valid`=0 and `rdata`=0 next cycle, no `done`.
- `downstream_stall` held 2 cycles in DONE → `done` held for those cycles, no new `dreq.valid`.
